// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// A two-state run control gates fetching, and redirects squash the wrong-path slot.
module fetch_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        enable,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [5:0]  opcode,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] branch_aligned;
    logic [31:0] jump_aligned;
    logic        active;
    logic        redirect;
    logic        load_bubble;
    logic        load_fetch;

    // The cycle in which enable is first seen already fetches, so the
    // first instruction appears one clock after enable rises.
    assign active   = (state_reg == RUN) || enable;
    assign redirect = branch_taken || jump;

    assign pc_plus4       = pc_reg + 32'd4;
    assign branch_aligned = {branch_target[31:2], 2'b00};
    assign jump_aligned   = {jump_target[31:2], 2'b00};

    always_comb begin
        pc_next = pc_reg;
        if (active) begin
            if (branch_taken) begin
                pc_next = branch_aligned;
            end else if (jump) begin
                pc_next = jump_aligned;
            end else if (!stall) begin
                pc_next = pc_plus4;
            end
        end
    end

    // Redirect and flush squash the slot even while stalled; stall alone holds it.
    always_comb begin
        load_bubble = 1'b0;
        load_fetch  = 1'b0;
        if (!active) begin
            load_bubble = 1'b1;
        end else if (redirect || flush) begin
            load_bubble = 1'b1;
        end else if (!stall) begin
            load_fetch = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (enable)  state_reg <= RUN;
                RUN:     if (!enable) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pc_reg <= PC_RESET;
        end else begin
            pc_reg <= pc_next;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
            opcode         <= 6'd0;
            fetch_count    <= 32'd0;
        end else if (load_bubble) begin
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
            opcode         <= NOP_INSTR[31:26];
        end else if (load_fetch) begin
            if_id_instr    <= imem_rdata;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
            opcode         <= imem_rdata[31:26];
            fetch_count    <= fetch_count + 32'd1;
        end
    end

    assign imem_addr = pc_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: run control, stalls, redirects, flush, PC wrap
// and asynchronous reset, with a small combinational instruction memory model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic        enable = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [5:0]  opcode;
    logic [31:0] fetch_count;

    int tests = 0;
    int failed = 0;

    fetch_stage #(.PC_RESET(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .arst(arst), .enable(enable), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid(if_id_valid), .opcode(opcode), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'd0) ? 32'h8C01_0004 : (a ^ 32'h5A5A_0000);
    endfunction

    assign imem_rdata = mem(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_addr"},  imem_addr, 32'h0);
        check({tag, "_instr"}, if_id_instr, NOP);
        check({tag, "_pc4"},   if_id_pc_plus4, 32'h0);
        check({tag, "_valid"}, {31'd0, if_id_valid}, 32'h0);
        check({tag, "_count"}, fetch_count, 32'h0);
        check({tag, "_opc"},   {26'd0, opcode}, 32'h0);
    endtask

    initial begin
        #2 arst = 1'b1;
        #1 check_reset("rst");
        step();
        step();
        arst = 1'b0;

        // IDLE holds PC and keeps bubbles
        step();
        step();
        check("idle_addr", imem_addr, 32'h0);
        check("idle_valid", {31'd0, if_id_valid}, 32'h0);
        check("idle_count", fetch_count, 32'h0);

        // First fetch one clock after enable
        enable = 1'b1;
        step();
        check("f0_instr", if_id_instr, 32'h8C01_0004);
        check("f0_opc", {26'd0, opcode}, 32'h23);
        check("f0_pc4", if_id_pc_plus4, 32'h4);
        check("f0_valid", {31'd0, if_id_valid}, 32'h1);
        check("f0_addr", imem_addr, 32'h4);
        check("f0_count", fetch_count, 32'h1);
        step();
        check("f4_instr", if_id_instr, 32'h5A5A_0004);
        check("f4_pc4", if_id_pc_plus4, 32'h8);
        check("f4_addr", imem_addr, 32'h8);
        check("f4_count", fetch_count, 32'h2);

        // Three-cycle stall at PC=8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr", imem_addr, 32'h8);
            check("stall_instr", if_id_instr, 32'h5A5A_0004);
            check("stall_count", fetch_count, 32'h2);
        end
        stall = 1'b0;
        step();
        check("unstall_addr", imem_addr, 32'hC);
        check("unstall_instr", if_id_instr, 32'h5A5A_0008);
        check("unstall_count", fetch_count, 32'h3);

        // Branch beats jump, target aligned, slot squashed
        branch_taken = 1'b1; branch_target = 32'h0000_0043;
        jump = 1'b1; jump_target = 32'h0000_0100;
        step();
        check("br_addr", imem_addr, 32'h40);
        check("br_valid", {31'd0, if_id_valid}, 32'h0);
        check("br_instr", if_id_instr, NOP);
        check("br_count", fetch_count, 32'h3);
        branch_taken = 1'b0;
        jump_target = 32'h0000_0203;
        step();
        check("jmp_addr", imem_addr, 32'h200);
        check("jmp_valid", {31'd0, if_id_valid}, 32'h0);
        jump = 1'b0;
        step();
        check("postjmp_instr", if_id_instr, 32'h5A5A_0200);
        check("postjmp_pc4", if_id_pc_plus4, 32'h204);
        check("postjmp_count", fetch_count, 32'h4);

        // Branch overrides stall
        branch_taken = 1'b1; branch_target = 32'h0000_0080; stall = 1'b1;
        step();
        check("brstall_addr", imem_addr, 32'h80);
        check("brstall_valid", {31'd0, if_id_valid}, 32'h0);
        branch_taken = 1'b0;

        // Stall + flush: PC held, bubble
        flush = 1'b1;
        step();
        check("sf_addr", imem_addr, 32'h80);
        check("sf_valid", {31'd0, if_id_valid}, 32'h0);
        check("sf_count", fetch_count, 32'h4);
        stall = 1'b0;
        step();
        check("fl_addr", imem_addr, 32'h84);
        check("fl_instr", if_id_instr, NOP);
        flush = 1'b0;
        step();
        check("postfl_instr", if_id_instr, 32'h5A5A_0084);
        check("postfl_count", fetch_count, 32'h5);

        // PC wrap at the top of the address space
        jump = 1'b1; jump_target = 32'hFFFF_FFFF;
        step();
        check("wrapj_addr", imem_addr, 32'hFFFF_FFFC);
        jump = 1'b0;
        step();
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc4", if_id_pc_plus4, 32'h0);
        check("wrap_instr", if_id_instr, 32'hA5A5_FFFC);
        check("wrap_count", fetch_count, 32'h6);

        // Drop enable; once idle, redirects are ignored
        enable = 1'b0;
        step();
        branch_taken = 1'b1; branch_target = 32'h0000_0300; flush = 1'b1;
        step();
        check("idle2_addr", imem_addr, 32'h4);
        check("idle2_valid", {31'd0, if_id_valid}, 32'h0);
        check("idle2_count", fetch_count, 32'h7);
        step();
        check("idle3_addr", imem_addr, 32'h4);
        branch_taken = 1'b0; flush = 1'b0;

        // Resume, then async reset between edges
        enable = 1'b1;
        step();
        check("res_addr", imem_addr, 32'h8);
        check("res_count", fetch_count, 32'h8);
        #2 arst = 1'b1;
        #1 check_reset("arst");
        #1 arst = 1'b0;
        step();
        check("restart_instr", if_id_instr, 32'h8C01_0004);
        check("restart_addr", imem_addr, 32'h4);
        check("restart_count", fetch_count, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: PC_RESET, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0000, bubble instruction placed in IF/ID on flush or reset.
REQ-003 Reset is asynchronous and active-high (arst); one clock (clk).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 arst  input  1  asynchronous active-high reset.
REQ-006 enable  input  1  start/run request; fetch begins only after first assertion.
REQ-007 stall  input  1  hazard hold: freeze PC and IF/ID register.
REQ-008 flush  input  1  squash IF/ID contents to bubble.
REQ-009 branch_taken  input  1  redirect from branch resolution.
REQ-010 branch_target  input  32  branch destination address.
REQ-011 jump  input  1  redirect from jump decode.
REQ-012 jump_target  input  32  jump destination address.
REQ-013 imem_addr  output  32  instruction memory address, equals current PC.
REQ-014 imem_rdata  input  32  instruction word, combinational read of imem_addr.
REQ-015 if_id_instr  output  32  registered instruction for decode.
REQ-016 if_id_pc_plus4  output  32  registered PC+4 of that instruction.
REQ-017 if_id_valid  output  1  1 = if_id_instr is a real fetched instruction.
REQ-018 opcode  output  6  if_id_instr[31:26], feeds the control unit.
REQ-019 fetch_count  output  32  number of instructions accepted into IF/ID.

Function
REQ-020 FSM states SHALL be IDLE and RUN; reset enters IDLE; IDLE->RUN when enable=1; RUN->IDLE when enable=0.
REQ-021 In IDLE the PC SHALL hold, and IF/ID SHALL load NOP_INSTR with valid=0 each cycle.
REQ-022 In RUN with no stall/redirect, each cycle: PC <= PC+4; IF/ID <= {imem_rdata, PC+4}, valid=1; fetch_count increments.
REQ-023 Next-PC priority SHALL be: branch_taken, then jump, then stall (hold), then PC+4.
REQ-024 Redirect targets SHALL have bits [1:0] forced to 2'b00 before loading PC.
REQ-025 On branch_taken or jump in RUN, IF/ID SHALL load NOP_INSTR with valid=0 (wrong-path squash), regardless of stall.
REQ-026 flush=1 SHALL load NOP_INSTR, valid=0 into IF/ID, overriding stall; PC follows REQ-023.
REQ-027 stall=1 without flush/redirect SHALL hold PC, IF/ID and fetch_count unchanged.
REQ-028 fetch_count SHALL increment only when IF/ID loads with valid=1; wraps 32'hFFFF_FFFF->0.
REQ-029 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-030 Redirect/stall/flush inputs SHALL be ignored in IDLE.
REQ-031 Latency: instruction at PC appears on if_id_instr one clock after imem_addr=PC.

Reset
REQ-032 On arst=1, immediately: PC=PC_RESET, state=IDLE, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0, fetch_count=0, opcode=0.
REQ-033 Reset asserted mid-operation SHALL discard in-flight IF/ID contents; fetch restarts at PC_RESET after enable.

Verification
REQ-034 Reset then enable=1, imem returns 32'h8C01_0004 at 0: after 1 clk if_id_instr=32'h8C01_0004, opcode=6'h23, pc_plus4=4, valid=1, imem_addr=4.
REQ-035 RUN, stall=1 for 3 cycles at PC=8: imem_addr stays 8, IF/ID and fetch_count unchanged; stall=0 -> PC=12 next clk.
REQ-036 branch_taken=1, branch_target=32'h0000_0043, jump=1 same cycle: PC=32'h40, if_id_valid=0, if_id_instr=NOP_INSTR.
REQ-037 stall=1 and flush=1 together: PC held, if_id_valid=0, fetch_count unchanged.
REQ-038 PC=32'hFFFF_FFFC, free run: next PC=0, if_id_pc_plus4=0.
REQ-039 arst pulsed mid-RUN between clock edges: outputs reach reset values without a clock edge; enable=1 resumes fetch at PC_RESET.
